// File: rtl/cntr_pkg.sv
// Shared types and default widths for the interval-timer controller.
// The optional prescaler is selected with CNTR_CTRL_PRESCALE_EN.
package cntr_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } cntr_state_e;

    localparam int CNTR_COUNT_WIDTH_DFLT    = 4;
    localparam int CNTR_PRESCALE_WIDTH_DFLT = 4;

endpackage

// File: rtl/cntr_prescale.sv
// Rate divider: pulses step once every div+1 cycles while clear is low.
// Only instantiated when CNTR_CTRL_PRESCALE_EN is defined.
module cntr_prescale #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic [WIDTH-1:0] div,
    output logic             step
);

    logic [WIDTH-1:0] cnt_reg;

    assign step = !clear && (cnt_reg == div);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg <= '0;
        end else if (clear || step) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_reg + WIDTH'(1);
        end
    end

endmodule

// File: rtl/cntr_ctrl.sv
// Interval-timer controller: start/stop/terminal-count/reload sequencing of a count register.
// Define CNTR_CTRL_PRESCALE_EN to build the prescaler; otherwise every RUN cycle is a step.
module cntr_ctrl
    import cntr_pkg::*;
#(
    parameter int COUNT_WIDTH    = CNTR_COUNT_WIDTH_DFLT,
    parameter int PRESCALE_WIDTH = CNTR_PRESCALE_WIDTH_DFLT
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic                      stop,
    input  logic                      reload,
    input  logic [COUNT_WIDTH-1:0]    period,
    input  logic [PRESCALE_WIDTH-1:0] prescale,
    output logic [COUNT_WIDTH-1:0]    count,
    output logic                      busy,
    output logic                      tc,
    output logic                      done
);

    cntr_state_e            state_reg;
    logic [COUNT_WIDTH-1:0] count_reg;
    logic [COUNT_WIDTH-1:0] period_q_reg;
    logic                   reload_q_reg;
    logic                   tc_reg;
    logic                   step;

`ifdef CNTR_CTRL_PRESCALE_EN
    logic [PRESCALE_WIDTH-1:0] prescale_q_reg;
    logic                      presc_clear;

    // Prescaler restarts from zero on every start and whenever not counting.
    assign presc_clear = (state_reg != RUN) || start || stop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prescale_q_reg <= '0;
        end else if (start && !stop) begin
            prescale_q_reg <= prescale;
        end
    end

    cntr_prescale #(
        .WIDTH (PRESCALE_WIDTH)
    ) u_prescale (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (presc_clear),
        .div   (prescale_q_reg),
        .step  (step)
    );
`else
    logic unused_prescale;

    assign unused_prescale = ^prescale;
    assign step            = (state_reg == RUN);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            count_reg    <= '0;
            period_q_reg <= '0;
            reload_q_reg <= 1'b0;
            tc_reg       <= 1'b0;
        end else begin
            tc_reg <= 1'b0;
            if (stop) begin
                state_reg <= IDLE;
                count_reg <= '0;
            end else if (start) begin
                state_reg    <= RUN;
                count_reg    <= '0;
                period_q_reg <= period;
                reload_q_reg <= reload;
            end else if (state_reg == RUN && step) begin
                if (count_reg == period_q_reg) begin
                    tc_reg <= 1'b1;
                    if (reload_q_reg) begin
                        count_reg <= '0;
                    end else begin
                        state_reg <= DONE;
                    end
                end else begin
                    count_reg <= count_reg + COUNT_WIDTH'(1);
                end
            end
        end
    end

    assign count = count_reg;
    assign busy  = (state_reg == RUN);
    assign done  = (state_reg == DONE);
    assign tc    = tc_reg;

endmodule
